// File: rtl/protect_latch.sv
// Protection latch: blanks gate drive on any filtered fault, captures the first-fault
// code, and re-arms only after a fault-free hold period and a fresh Clr rising edge.
`timescale 1ns/1ps
module protect_latch #(
    parameter logic [7:0] HOLD_CYC = 8'd200
) (
    input  logic       clk,
    input  logic       Rst_n,
    input  logic [3:0] Prt_dly,
    input  logic       Clr,
    input  logic [3:0] PWM_in,
    output logic [3:0] PWM_out,
    output logic       Flt_n,
    output logic [3:0] Flt_code
);

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_TRIP     = 3'd1,
        ST_HOLD     = 3'd2,
        ST_WAIT_CLR = 3'd3
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] code_q, code_d;
    logic       clr_q;
    logic       flt_n_q;
    logic       fault_s;
    logic       clr_rise_s;

    assign fault_s    = |Prt_dly;
    assign clr_rise_s = Clr & ~clr_q;

    // State register; Clr history resets high so a Clr held through reset is not an edge
    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            state_q <= ST_HOLD;
            cnt_q   <= 8'd0;
            code_q  <= 4'b0000;
            clr_q   <= 1'b1;
            flt_n_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            clr_q   <= Clr;
            flt_n_q <= (state_d == ST_RUN);
        end
    end

    // Next-state, hold counter and first-fault capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        case (state_q)
            ST_RUN: begin
                if (fault_s) begin
                    state_d = ST_TRIP;
                    code_d  = Prt_dly;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_TRIP: begin
                state_d = ST_HOLD;
                cnt_d   = 8'd0;
            end
            ST_HOLD: begin
                if (fault_s) begin
                    cnt_d = 8'd0;
                end else if (cnt_q >= HOLD_CYC) begin
                    state_d = ST_WAIT_CLR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_WAIT_CLR: begin
                // A fault in the same cycle as the Clr edge wins
                if (fault_s) begin
                    state_d = ST_HOLD;
                    cnt_d   = 8'd0;
                end else if (clr_rise_s) begin
                    state_d = ST_RUN;
                    code_d  = 4'b0000;
                end else begin
                    state_d = ST_WAIT_CLR;
                end
            end
            default: begin
                state_d = ST_TRIP;
            end
        endcase
    end

    // Gate drive passes only in RUN with no fault present, blanking in the fault cycle itself
    always_comb begin
        if ((state_q == ST_RUN) && !fault_s && Rst_n) begin
            PWM_out = PWM_in;
        end else begin
            PWM_out = 4'b0000;
        end
    end

    assign Flt_n    = flt_n_q;
    assign Flt_code = code_q;

endmodule

// File: tb/tb_protect_latch.sv
// Directed bench for protect_latch: each stimulus cycle queues its expected outputs,
// a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_protect_latch;

    logic       clk;
    logic       Rst_n;
    logic [3:0] Prt_dly;
    logic       Clr;
    logic [3:0] PWM_in;
    logic [3:0] PWM_out;
    logic       Flt_n;
    logic [3:0] Flt_code;

    typedef struct {
        string      name;
        logic [3:0] pwm;
        logic       fltn;
        logic [3:0] code;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    protect_latch #(.HOLD_CYC(8'd200)) dut (
        .clk      (clk),
        .Rst_n    (Rst_n),
        .Prt_dly  (Prt_dly),
        .Clr      (Clr),
        .PWM_in   (PWM_in),
        .PWM_out  (PWM_out),
        .Flt_n    (Flt_n),
        .Flt_code (Flt_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every queued expectation against the outputs at the falling edge
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (PWM_out !== e.pwm)
                $display("FAIL %s PWM_out: got %h expected %h at %0t", e.name, PWM_out, e.pwm, $time);
            else
                n_pass++;
            n_checks++;
            if (Flt_n !== e.fltn)
                $display("FAIL %s Flt_n: got %b expected %b at %0t", e.name, Flt_n, e.fltn, $time);
            else
                n_pass++;
            n_checks++;
            if (Flt_code !== e.code)
                $display("FAIL %s Flt_code: got %b expected %b at %0t", e.name, Flt_code, e.code, $time);
            else
                n_pass++;
        end
    end

    task automatic drive(input logic rst, input logic [3:0] prt, input logic clr, input logic [3:0] pwm);
        @(posedge clk);
        #1;
        Rst_n   = rst;
        Prt_dly = prt;
        Clr     = clr;
        PWM_in  = pwm;
    endtask

    task automatic cyc(input string nm, input logic rst, input logic [3:0] prt, input logic clr,
                       input logic [3:0] pwm, input logic [3:0] e_pwm, input logic e_fltn,
                       input logic [3:0] e_code);
        exp_t e;
        drive(rst, prt, clr, pwm);
        e.name = nm;
        e.pwm  = e_pwm;
        e.fltn = e_fltn;
        e.code = e_code;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n   = 1'b0;
        Prt_dly = 4'b0000;
        Clr     = 1'b0;
        PWM_in  = 4'hF;
        repeat (3) @(posedge clk);
        cyc("reset", 1'b0, 4'b0000, 1'b0, 4'hF, 4'h0, 1'b0, 4'b0000);

        // Boot: HOLD reaches 200 at cycle 200, WAIT_CLR at 201; Clr at 100/200 ignored, 205 accepted
        for (int c = 0; c <= 206; c++) begin
            cyc("boot", 1'b1, 4'b0000, (c == 100 || c == 200 || c == 205), 4'h5,
                (c >= 206) ? 4'h5 : 4'h0, (c >= 206), 4'b0000);
        end

        // Single fault: blank same cycle, latch code and drop Flt_n next edge
        cyc("run_pwm",    1'b1, 4'b0000, 1'b0, 4'hF, 4'hF, 1'b1, 4'b0000);
        cyc("trip_blank", 1'b1, 4'b0100, 1'b0, 4'hF, 4'h0, 1'b1, 4'b0000);
        cyc("trip_latch", 1'b1, 4'b0000, 1'b0, 4'hF, 4'h0, 1'b0, 4'b0100);
        for (int i = 1; i <= 205; i++) begin
            cyc("hold_clr_held", 1'b1, 4'b0000, (i == 201 || i == 202 || i == 203 || i == 205), 4'hF,
                4'h0, 1'b0, 4'b0100);
        end
        cyc("rerun1", 1'b1, 4'b0000, 1'b0, 4'hF, 4'hF, 1'b1, 4'b0000);

        // Simultaneous faults, later fault in HOLD, fault beating Clr in WAIT_CLR
        cyc("multi",      1'b1, 4'b0011, 1'b0, 4'hF, 4'h0, 1'b1, 4'b0000);
        cyc("multi_code", 1'b1, 4'b0000, 1'b0, 4'hF, 4'h0, 1'b0, 4'b0011);
        for (int i = 1; i <= 456; i++) begin
            cyc("multi_hold", 1'b1,
                (i == 51) ? 4'b1000 : ((i == 253) ? 4'b0001 : 4'b0000),
                (i == 251 || i == 253 || i == 454 || i == 456), 4'hF,
                4'h0, 1'b0, 4'b0011);
        end
        cyc("rerun2", 1'b1, 4'b0000, 1'b0, 4'hF, 4'hF, 1'b1, 4'b0000);

        // Glitch at counter 150: WAIT_CLR only after 201 fault-free cycles
        cyc("g_fault", 1'b1, 4'b0001, 1'b0, 4'hF, 4'h0, 1'b1, 4'b0000);
        for (int i = 0; i <= 353; i++) begin
            cyc("glitch_hold", 1'b1, (i == 151) ? 4'b0010 : 4'b0000, (i == 353), 4'hF,
                4'h0, 1'b0, 4'b0001);
        end
        cyc("rerun3", 1'b1, 4'b0000, 1'b0, 4'hF, 4'hF, 1'b1, 4'b0000);

        // Reset in RUN, then reset aborting WAIT_CLR with Clr held high
        cyc("rst_run", 1'b1, 4'b0000, 1'b0, 4'hA, 4'hA, 1'b1, 4'b0000);
        drive(1'b0, 4'b0000, 1'b0, 4'hA);
        for (int i = 0; i <= 206; i++) begin
            cyc("rst_hold", (i == 202) ? 1'b0 : 1'b1, 4'b0000,
                (i <= 203 || i == 205), 4'hA, 4'h0, 1'b0, 4'b0000);
        end

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        else
            n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
